ras_predictor: RTL and testbench
================================

# ras_predictor

Parametrised return-address stack (RAS) for the RISC-V fetch stage. It decodes each fetched JAL/JALR and pushes the link address on calls. On returns it pops and supplies a predicted target in the same cycle, so the fetch stage can redirect without waiting for the register-file read of `rs1`. The block sits beside the PC register, feeds the `pc_src` selection, and is fully decoupled from the datapath ALU.

## Interface
Parameters:
- `XLEN`, 32: address width.
- `DEPTH`, 8: stack entries; power of two, minimum 2.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  `instr`/`pc` are a real fetched instruction this cycle.
- `instr`  in  32  fetched instruction word.
- `pc`  in  XLEN  address of `instr`.
- `pred_valid`  out  1  `pred_target` is a usable return prediction.
- `pred_target`  out  XLEN  predicted return address.
- `count`  out  $clog2(DEPTH)+1  live entries.
- `ovf`  out  1  sticky: an entry was overwritten since reset.
- `ckpt_save`  in  1  snapshot pointer state (macro-gated).
- `ckpt_restore`  in  1  restore snapshot (macro-gated).

## Operation
Decoding covers only `opcode` 1101111 (JAL) and 1100111 with `funct3`=000 (JALR). Link registers are x1 and x5.
- **Call:** JAL or JALR with `rd` ∈ {x1,x5}.
- **Return:** JALR with `rs1` ∈ {x1,x5} and `rd` ∉ {x1,x5}.
- **Coroutine:** JALR with `rd`,`rs1` both link and `rd`≠`rs1`. This is a pop followed by a push in one cycle: the top entry is replaced with `pc+4`, and `count` is unchanged.
- JALR with `rd`==`rs1`, both link, is a plain call.
- All other instructions: no effect.

Push behaviour:
- Write `pc+4` (XLEN wrap) at `tos+1` mod DEPTH.
- `tos` advances and `count` increments, saturating at DEPTH.
- A push when full overwrites the oldest entry (circular) and sets `ovf`.

Pop behaviour:
- If `count`>0: `tos` retreats mod DEPTH and `count` decrements.
- If `count`==0 (underflow): no state change and `pred_valid`=0.

Prediction:
- `pred_valid` = `instr_valid` & (return | coroutine) & `count`>0.
- `pred_target` = `mem[tos]`. It is driven regardless of validity and is defined only when `pred_valid`=1.

Additional rules:
- When `instr_valid`=0, nothing is decoded and there is no state change.
- Entry contents are never cleared except by reset.

## Timing
- Prediction is combinational from `instr`/`pc` to `pred_*` within the same cycle.
- Stack update is committed on the rising `clk` edge of the same cycle. The next cycle's prediction sees the new top.
- Back-to-back call→return on consecutive cycles must predict the just-pushed `pc+4`.
- Reset values while `rst`=0, applied asynchronously:
  - `tos`=0, `count`=0, `ovf`=0, all entries 0.
  - `pred_valid`=0 and `pred_target`=0.
  - Checkpoint registers = 0.
- Reset released mid-sequence: the first valid instruction after release sees an empty stack.

## Configuration
- `RAS_CHECKPOINT_EN` defined:
  - `ckpt_save` latches {`tos`,`count`} at the clock edge.
  - `ckpt_restore` reloads them at the clock edge and takes priority over any push or pop that cycle. Entries are not restored.
  - Save and restore together: restore wins, and the snapshot is then overwritten with the restored values.
- Not defined: both inputs exist but are ignored, no checkpoint flops are built, and the stack is never repaired on misprediction.

## Structure
- Shared package `riscv/ras.svh`:
  - `ras_op_e` with values RAS_NONE, RAS_PUSH, RAS_POP, RAS_POPPUSH.
  - Opcode constants OP_JAL=7'b1101111 and OP_JALR=7'b1100111.
  - Link register indices 1 and 5.
- One sub-module, `ras_decode`: combinational `instr`→`ras_op_e`.
- The stack storage, pointers and checkpoint stay in `ras_predictor`.

## Test plan
- Reset, then `0x004180e7` (`jalr ra,x3,4`) at `pc`=0:
  - push 4, `count`=1, `pred_valid`=0.
  - Next, `0x00008067` (`ret`) at `pc`=12: `pred_valid`=1, `pred_target`=4, `count`=0 after the edge.
- `ret` on an empty stack → `pred_valid`=0, `count` stays 0, `ovf`=0.
- DEPTH=8: ten `0x008000ef` (`jal ra,8`) at `pc`=0,4,…,36:
  - `count`=8, `ovf`=1.
  - Eight `ret`s predict 40,36,…,12.
  - The ninth has `pred_valid`=0.
- Coroutine: push 0x100, then `jalr t0,ra,0` (`0x000082e7`) at `pc`=0x200:
  - `pred_target`=0x100.
  - After the edge the top is 0x204 and `count`=1.
- `RAS_CHECKPOINT_EN`:
  - Push 0x10 and 0x20, then `ckpt_save`.
  - Push 0x30, pop twice, then `ckpt_restore`.
  - Result: `count`=2 and `pred_target` for the next `ret` = 0x20.
- Assert `rst` low mid-stream with `count`=3 → all outputs are 0 immediately, and the next `ret` has `pred_valid`=0.

Source files
------------

// File: rtl/ras_predictor_pkg.sv
// rtl/ras_predictor_pkg.sv - shared RAS op encoding, opcode and link-register constants
package ras_predictor_pkg;

   typedef enum logic [1:0] {
      RAS_NONE,
      RAS_PUSH,
      RAS_POP,
      RAS_POPPUSH
   } ras_op_e;

   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [2:0] F3_JALR  = 3'b000;
   localparam logic [4:0] LINK_RA  = 5'd1;
   localparam logic [4:0] LINK_T0  = 5'd5;

   function automatic logic is_link(input logic [4:0] r);
      return (r == LINK_RA) || (r == LINK_T0);
   endfunction

endpackage

// File: rtl/ras_decode.sv
// rtl/ras_decode.sv - combinational JAL/JALR classifier producing the stack operation
module ras_decode
   import ras_predictor_pkg::*;
(
   input  logic [31:0] i_instr,
   output ras_op_e     o_op
);

   logic [6:0] w_opcode;
   logic [4:0] w_rd;
   logic [4:0] w_rs1;
   logic [2:0] w_funct3;
   logic       w_rd_link;
   logic       w_rs1_link;
   logic       w_unused_imm;

   assign w_opcode     = i_instr[6:0];
   assign w_rd         = i_instr[11:7];
   assign w_funct3     = i_instr[14:12];
   assign w_rs1        = i_instr[19:15];
   assign w_rd_link    = is_link(w_rd);
   assign w_rs1_link   = is_link(w_rs1);
   assign w_unused_imm = ^i_instr[31:20];

   always_comb begin
      o_op = RAS_NONE;
      if (w_opcode == OP_JAL) begin
         if (w_rd_link) o_op = RAS_PUSH;
      end else if ((w_opcode == OP_JALR) && (w_funct3 == F3_JALR)) begin
         // Same link register on both sides is treated as a plain call
         if (w_rd_link && w_rs1_link) o_op = (w_rd != w_rs1) ? RAS_POPPUSH : RAS_PUSH;
         else if (w_rd_link)          o_op = RAS_PUSH;
         else if (w_rs1_link)         o_op = RAS_POP;
      end
   end

endmodule

// File: rtl/ras_predictor.sv
// rtl/ras_predictor.sv - circular return-address stack; RAS_CHECKPOINT_EN adds pointer snapshot/restore
module ras_predictor
   import ras_predictor_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     instr_valid,
   input  logic [31:0]              instr,
   input  logic [XLEN-1:0]          pc,
   output logic                     pred_valid,
   output logic [XLEN-1:0]          pred_target,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf,
   input  logic                     ckpt_save,
   input  logic                     ckpt_restore
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [XLEN-1:0] r_mem [DEPTH];
   logic [PW-1:0]   r_tos;
   logic [CW-1:0]   r_count;
   logic            r_ovf;

   ras_op_e         w_op;
   logic            w_full;
   logic            w_empty;
   logic [PW-1:0]   w_tos_inc;
   logic [PW-1:0]   w_tos_dec;
   logic [XLEN-1:0] w_link;
   logic            w_push;
   logic            w_replace;
   logic            w_pop;
   logic            w_restore;
   logic [PW-1:0]   w_ckpt_tos;
   logic [CW-1:0]   w_ckpt_count;

   ras_decode u_decode (
      .i_instr (instr),
      .o_op    (w_op)
   );

   assign w_full    = (r_count == CW'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_tos_inc = r_tos + PW'(1);
   assign w_tos_dec = r_tos - PW'(1);
   assign w_link    = pc + XLEN'(4);

   // A coroutine on an empty stack degenerates to a push: its pop has nothing to remove
   assign w_push    = instr_valid & ((w_op == RAS_PUSH) | ((w_op == RAS_POPPUSH) & w_empty));
   assign w_replace = instr_valid & (w_op == RAS_POPPUSH) & ~w_empty;
   assign w_pop     = instr_valid & (w_op == RAS_POP) & ~w_empty;

   assign pred_valid  = instr_valid & ((w_op == RAS_POP) | (w_op == RAS_POPPUSH)) & ~w_empty;
   assign pred_target = r_mem[r_tos];
   assign count       = r_count;
   assign ovf         = r_ovf;

`ifdef RAS_CHECKPOINT_EN
   logic [PW-1:0] r_ckpt_tos;
   logic [CW-1:0] r_ckpt_count;

   assign w_restore    = ckpt_restore;
   assign w_ckpt_tos   = r_ckpt_tos;
   assign w_ckpt_count = r_ckpt_count;

   // On restore the snapshot is rewritten with itself, so holding it is equivalent
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ckpt_tos   <= '0;
         r_ckpt_count <= '0;
      end else if (!ckpt_restore && ckpt_save) begin
         r_ckpt_tos   <= r_tos;
         r_ckpt_count <= r_count;
      end
   end
`else
   logic w_unused_ckpt;

   assign w_unused_ckpt = ckpt_save | ckpt_restore;
   assign w_restore     = 1'b0;
   assign w_ckpt_tos    = '0;
   assign w_ckpt_count  = '0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (!w_restore) begin
         if (w_push)         r_mem[w_tos_inc] <= w_link;
         else if (w_replace) r_mem[r_tos]     <= w_link;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tos   <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else if (w_restore) begin
         r_tos   <= w_ckpt_tos;
         r_count <= w_ckpt_count;
      end else if (w_push) begin
         r_tos <= w_tos_inc;
         if (w_full) r_ovf   <= 1'b1;
         else        r_count <= r_count + CW'(1);
      end else if (w_pop) begin
         r_tos   <= w_tos_dec;
         r_count <= r_count - CW'(1);
      end
   end

endmodule

// File: tb/tb_ras_predictor.sv
// tb/tb_ras_predictor.sv - scoreboard bench for ras_predictor; RAS_CHECKPOINT_EN selects checkpoint expectations
module tb_ras_predictor;

   localparam logic [31:0] JALR_RA_X3 = 32'h004180e7;
   localparam logic [31:0] RET        = 32'h00008067;
   localparam logic [31:0] JAL_RA     = 32'h008000ef;
   localparam logic [31:0] CORO       = 32'h000082e7;
   localparam logic [31:0] JALR_RA_RA = 32'h000080e7;
   localparam logic [31:0] NOP        = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        instr_valid = 1'b0;
   logic [31:0] instr = '0;
   logic [31:0] pc = '0;
   logic        ckpt_save = 1'b0;
   logic        ckpt_restore = 1'b0;
   logic        pred_valid;
   logic [31:0] pred_target;
   logic [3:0]  count;
   logic        ovf;

   typedef struct {
      string       name;
      logic        pv;
      logic [31:0] tgt;
      logic [3:0]  cnt;
      logic        ov;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_assert = 0;
   int   n_fail = 0;

   ras_predictor #(.XLEN(32), .DEPTH(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .instr_valid  (instr_valid),
      .instr        (instr),
      .pc           (pc),
      .pred_valid   (pred_valid),
      .pred_target  (pred_target),
      .count        (count),
      .ovf          (ovf),
      .ckpt_save    (ckpt_save),
      .ckpt_restore (ckpt_restore)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic issue(input string name, input logic [31:0] i, input logic [31:0] p,
                        input logic pv, input logic [31:0] tgt, input logic [3:0] cnt, input logic ov);
      exp_t x;
      @(posedge clk);
      #1;
      instr_valid  = 1'b1;
      instr        = i;
      pc           = p;
      ckpt_save    = 1'b0;
      ckpt_restore = 1'b0;
      x.name = name; x.pv = pv; x.tgt = tgt; x.cnt = cnt; x.ov = ov;
      sb.push_back(x);
   endtask

   task automatic idle(input logic [31:0] i);
      @(posedge clk);
      #1;
      instr_valid  = 1'b0;
      instr        = i;
      ckpt_save    = 1'b0;
      ckpt_restore = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   always @(negedge clk) begin
      if (rst && instr_valid) begin
         if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL scoreboard_underrun: got output with no expectation, required one queued");
         end else begin
            e = sb.pop_front();
            chk({e.name, "_pred_valid"}, 32'(pred_valid), 32'(e.pv));
            if (e.pv) chk({e.name, "_pred_target"}, pred_target, e.tgt);
            chk({e.name, "_count"}, 32'(count), 32'(e.cnt));
            chk({e.name, "_ovf"}, 32'(ovf), 32'(e.ov));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      #2;
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_ovf", 32'(ovf), 32'd0);
      chk("reset_pred_valid", 32'(pred_valid), 32'd0);
      chk("reset_pred_target", pred_target, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      issue("call_jalr", JALR_RA_X3, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0);
      issue("ret_after_call", RET, 32'd12, 1'b1, 32'd4, 4'd1, 1'b0);
      issue("ret_empty", RET, 32'd16, 1'b0, 32'd0, 4'd0, 1'b0);
      issue("nop_after_empty", NOP, 32'd20, 1'b0, 32'd0, 4'd0, 1'b0);

      for (int i = 0; i < 10; i++)
         issue("jal_fill", JAL_RA, 32'(4 * i), 1'b0, 32'd0, (i < 8) ? 4'(i) : 4'd8, (i == 9));
      for (int k = 0; k < 8; k++)
         issue("ret_drain", RET, 32'h300 + 32'(4 * k), 1'b1, 32'(40 - 4 * k), 4'(8 - k), 1'b1);
      issue("ret_ninth", RET, 32'h320, 1'b0, 32'd0, 4'd0, 1'b1);

      do_reset();
      issue("coro_push", JAL_RA, 32'h0fc, 1'b0, 32'd0, 4'd0, 1'b0);
      issue("coro", CORO, 32'h200, 1'b1, 32'h100, 4'd1, 1'b0);
      issue("ret_after_coro", RET, 32'h300, 1'b1, 32'h204, 4'd1, 1'b0);
      issue("nop_after_coro", NOP, 32'h304, 1'b0, 32'd0, 4'd0, 1'b0);
      issue("call_ra_ra", JALR_RA_RA, 32'h400, 1'b0, 32'd0, 4'd0, 1'b0);
      idle(RET);
      issue("nop_after_invalid", NOP, 32'h408, 1'b0, 32'd0, 4'd1, 1'b0);
      issue("ret_ra_ra", RET, 32'h40c, 1'b1, 32'h404, 4'd1, 1'b0);
      issue("nop_after_ra_ra", NOP, 32'h410, 1'b0, 32'd0, 4'd0, 1'b0);

      do_reset();
      issue("ck_push10", JAL_RA, 32'h0c, 1'b0, 32'd0, 4'd0, 1'b0);
      issue("ck_push20", JAL_RA, 32'h1c, 1'b0, 32'd0, 4'd1, 1'b0);
      issue("ck_save", NOP, 32'h30, 1'b0, 32'd0, 4'd2, 1'b0);
      ckpt_save = 1'b1;
      issue("ck_push30", JAL_RA, 32'h2c, 1'b0, 32'd0, 4'd2, 1'b0);
      issue("ck_pop30", RET, 32'h40, 1'b1, 32'h30, 4'd3, 1'b0);
      issue("ck_pop20", RET, 32'h44, 1'b1, 32'h20, 4'd2, 1'b0);
      issue("ck_restore", NOP, 32'h48, 1'b0, 32'd0, 4'd1, 1'b0);
      ckpt_restore = 1'b1;
`ifdef RAS_CHECKPOINT_EN
      issue("ck_ret_restored", RET, 32'h4c, 1'b1, 32'h20, 4'd2, 1'b0);
`else
      issue("ck_ret_ignored", RET, 32'h4c, 1'b1, 32'h10, 4'd1, 1'b0);
`endif

      do_reset();
      issue("mid_push0", JAL_RA, 32'd0, 1'b0, 32'd0, 4'd0, 1'b0);
      issue("mid_push1", JAL_RA, 32'd4, 1'b0, 32'd0, 4'd1, 1'b0);
      issue("mid_push2", JAL_RA, 32'd8, 1'b0, 32'd0, 4'd2, 1'b0);
      issue("mid_nop", NOP, 32'd12, 1'b0, 32'd0, 4'd3, 1'b0);
      @(posedge clk);
      #1;
      instr = RET;
      pc = 32'h50;
      #1;
      chk("mid_pre_pred_valid", 32'(pred_valid), 32'd1);
      chk("mid_pre_pred_target", pred_target, 32'd12);
      rst = 1'b0;
      #1;
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_ovf", 32'(ovf), 32'd0);
      chk("mid_rst_pred_valid", 32'(pred_valid), 32'd0);
      chk("mid_rst_pred_target", pred_target, 32'd0);
      instr_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      issue("ret_after_reset", RET, 32'h54, 1'b0, 32'd0, 4'd0, 1'b0);

      idle(NOP);
      @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
